// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
//   - funct3 load-type encodings (LB, LH, LW, LBU, LHU)
//   - ld_entry_t: one buffered load response {rd, funct3, addr_lo, data}
//   - ld_extend(): byte/half selection and sign/zero extension of load data
package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] data;
  } ld_entry_t;

  // Half-word select uses addr_lo[1] only; misaligned halves are not split.
  function automatic logic [31:0] ld_extend(input logic [2:0]  funct3,
                                            input logic [1:0]  addr_lo,
                                            input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{addr_lo, 3'b000} +: 8];
    h = data[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      LB:      ld_extend = {{24{b[7]}}, b};
      LH:      ld_extend = {{16{h[15]}}, h};
      LBU:     ld_extend = {24'h0, b};
      LHU:     ld_extend = {16'h0, h};
      default: ld_extend = data;
    endcase
  endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// Synchronous FIFO holding load responses until they win writeback arbitration.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i         enqueue data_i (caller guarantees not full)
//   pop_i          dequeue head (caller guarantees not empty)
//   flush_i        discard all entries; overrides push/pop
//   data_i         entry to enqueue
//   full_o/empty_o occupancy flags, registered state only
//   head_o         oldest entry
module wb_ld_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  ld_entry_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output ld_entry_t head_o
);

  localparam int unsigned AW = $clog2(Depth);

  ld_entry_t       mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: merges single-cycle ALU results with buffered
// load responses into one registered write per cycle, with ALU starvation guard.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   irq_flush_i                  drop all pending loads and the presented write
//   axi_stall_i                  core stall; outputs and arbitration freeze
//   alu_valid_i/alu_ready_o      ALU result handshake (alu_rd_i, alu_data_i)
//   ld_valid_i/ld_ready_o        load response handshake (ld_rd_i, ld_funct3_i,
//                                ld_addr_lo_i, ld_data_i)
//   wb_we_o, wb_rd_o, wb_data_o  registered write to the register file
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned LD_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_flush_i,
  input  logic        axi_stall_i,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_rd_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_data_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  ld_entry_t fifo_in, fifo_head;

  logic          advance, head_first, alu_win, ld_win;
  logic [SW-1:0] starve_q, starve_d;
  logic          wb_we_q, wb_we_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;

  assign fifo_in = '{rd: ld_rd_i, funct3: ld_funct3_i, addr_lo: ld_addr_lo_i, data: ld_data_i};

  wb_ld_fifo #(
    .Depth(LD_DEPTH)
  ) u_ld_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .flush_i(irq_flush_i),
    .data_i (fifo_in),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  always_comb begin
    advance    = !axi_stall_i && !irq_flush_i;
    // Loads take priority until the ALU has been passed over STARVE_MAX times.
    head_first = !fifo_empty && (starve_q < SW'(STARVE_MAX));
    alu_win    = advance && alu_valid_i && !head_first;
    ld_win     = advance && !fifo_empty && !alu_win;

    alu_ready_o = alu_win && !rst;
    ld_ready_o  = !fifo_full && !irq_flush_i && !rst;
    fifo_push   = ld_valid_i && ld_ready_o;
    fifo_pop    = ld_win && !rst;
  end

  always_comb begin
    starve_d  = starve_q;
    wb_we_d   = wb_we_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (irq_flush_i) begin
      starve_d = '0;
      wb_we_d  = 1'b0;
    end else if (advance) begin
      if (alu_valid_i && ld_win) begin
        starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
      if (alu_win) begin
        wb_we_d   = (alu_rd_i != 5'd0);
        wb_rd_d   = alu_rd_i;
        wb_data_d = alu_data_i;
      end else if (ld_win) begin
        wb_we_d   = (fifo_head.rd != 5'd0);
        wb_rd_d   = fifo_head.rd;
        wb_data_d = ld_extend(fifo_head.funct3, fifo_head.addr_lo, fifo_head.data);
      end else begin
        wb_we_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we_o   = wb_we_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;

endmodule
